// File: rtl/song_writer.sv
// UART-fed song loader: 8N1 receiver plus frame parser that writes note words into the song regfile.
// Optional checksum byte at frame end is enabled by defining SONG_WR_CHECKSUM_EN.
module song_writer #(
   parameter int CLK_DIV = 868,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        rx,
   output logic [15:0] addr_c,
   output logic [11:0] data_c,
   output logic        wen_c,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  last_len
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef SONG_WR_CHECKSUM_EN
   typedef enum logic [2:0] {P_IDLE, P_SEL, P_LEN, P_HI, P_LO, P_CHK} p_state_t;
`else
   typedef enum logic [2:0] {P_IDLE, P_SEL, P_LEN, P_HI, P_LO} p_state_t;
`endif

   rx_state_t       rx_state, rx_nxt;
   logic            rx_s1, rx_s2, rx_d;
   logic [CW-1:0]   cnt;
   logic [2:0]      bitn;
   logic [7:0]      rx_byte;
   logic            rx_valid, frame_err;

   p_state_t        p_state, p_nxt;
   logic [2:0]      sel;
   logic [7:0]      len, idx;
   logic [3:0]      hi;
   logic [TW-1:0]   tmo;
   logic            wr, fin, abort;
`ifdef SONG_WR_CHECKSUM_EN
   logic [7:0]      chk;
`endif

   // Receiver: start is an edge, not a level, so a low line after a framing error cannot retrigger.
   always_comb begin
      rx_nxt = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_d && !rx_s2) rx_nxt = RX_START;
         RX_START: if (cnt == HALF_LAST) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt == BIT_LAST && bitn == 3'd7) rx_nxt = RX_STOP;
         RX_STOP:  if (cnt == BIT_LAST) rx_nxt = RX_IDLE;
         default:  rx_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_d      <= 1'b1;
         cnt       <= '0;
         bitn      <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_state  <= rx_nxt;
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         rx_d      <= rx_s2;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (rx_state == RX_IDLE) begin
            cnt  <= '0;
            bitn <= '0;
         end else if (rx_state == RX_START) begin
            cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
         end else if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_state == RX_DATA) begin
               rx_byte <= {rx_s2, rx_byte[7:1]};
               bitn    <= bitn + 1'b1;
            end else begin
               rx_valid  <= rx_s2;
               frame_err <= !rx_s2;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Parser: abort sources ranked enable drop > timeout > framing error / byte.
   always_comb begin
      p_nxt = p_state;
      wr    = 1'b0;
      fin   = 1'b0;
      abort = 1'b0;
      if (p_state != P_IDLE && !enable) begin
         abort = 1'b1;
         p_nxt = P_IDLE;
      end else if (p_state != P_IDLE && tmo == TMO_MAX) begin
         abort = 1'b1;
         p_nxt = P_IDLE;
      end else if (p_state != P_IDLE && frame_err) begin
         abort = 1'b1;
         p_nxt = P_IDLE;
      end else if (rx_valid) begin
         case (p_state)
            P_IDLE: if (enable && rx_byte == 8'hA5) p_nxt = P_SEL;
            P_SEL: begin
               if (rx_byte > 8'd7) begin
                  abort = 1'b1;
                  p_nxt = P_IDLE;
               end else p_nxt = P_LEN;
            end
            P_LEN: begin
               if (rx_byte == 8'd0) begin
                  abort = 1'b1;
                  p_nxt = P_IDLE;
               end else p_nxt = P_HI;
            end
            P_HI: p_nxt = P_LO;
            P_LO: begin
               wr = 1'b1;
               if (idx == len - 8'd1) begin
`ifdef SONG_WR_CHECKSUM_EN
                  p_nxt = P_CHK;
`else
                  fin   = 1'b1;
                  p_nxt = P_IDLE;
`endif
               end else p_nxt = P_HI;
            end
`ifdef SONG_WR_CHECKSUM_EN
            P_CHK: begin
               fin   = (rx_byte == chk);
               abort = (rx_byte != chk);
               p_nxt = P_IDLE;
            end
`endif
            default: p_nxt = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_state  <= P_IDLE;
         sel      <= '0;
         len      <= '0;
         idx      <= '0;
         hi       <= '0;
         tmo      <= '0;
         addr_c   <= '0;
         data_c   <= '0;
         wen_c    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         last_len <= '0;
`ifdef SONG_WR_CHECKSUM_EN
         chk      <= '0;
`endif
      end else begin
         p_state <= p_nxt;
         wen_c   <= wr;
         done    <= fin;
         err     <= abort;
         if (p_state == P_IDLE || rx_valid) tmo <= '0;
         else if (tmo != TMO_MAX) tmo <= tmo + 1'b1;
         if (rx_valid) begin
            case (p_state)
               P_SEL: sel <= rx_byte[2:0];
               P_LEN: begin
                  len <= rx_byte;
                  idx <= '0;
               end
               P_HI:    hi <= rx_byte[3:0];
               default: ;
            endcase
`ifdef SONG_WR_CHECKSUM_EN
            if (p_state == P_SEL) chk <= rx_byte;
            else if (p_state == P_LEN || p_state == P_HI || p_state == P_LO) chk <= chk ^ rx_byte;
`endif
         end
         if (wr) begin
            addr_c <= {5'b0, sel, idx};
            data_c <= {hi, rx_byte};
            idx    <= idx + 8'd1;
         end
         if (fin) last_len <= len;
      end
   end

   assign busy = (p_state != P_IDLE);
endmodule

// File: tb/tb_song_writer.sv
// Directed bench for song_writer: serial frames in, regfile writes and done/err pulses checked.
module tb_song_writer;
   localparam int CLK_DIV = 16;
   localparam int TIMEOUT = 400;

   logic        clk = 1'b0;
   logic        rst, enable, rx;
   logic [15:0] addr_c;
   logic [11:0] data_c;
   logic        wen_c, busy, done, err;
   logic [7:0]  last_len;

   int vectors = 0;
   int miscompares = 0;
   int n_done = 0, n_err = 0, n_both = 0;
   int cyc = 0, wen_cyc = 0, done_cyc = 0;
   logic [27:0] wr_q[$];
   logic [27:0] exp_q[$];
   logic [7:0]  frame_q[$];

   song_writer #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .rx(rx),
      .addr_c(addr_c), .data_c(data_c), .wen_c(wen_c),
      .busy(busy), .done(done), .err(err), .last_len(last_len)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (wen_c) begin
         wr_q.push_back({addr_c, data_c});
         wen_cyc <= cyc;
      end
      if (done) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (err) n_err <= n_err + 1;
      if (done && err) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_obs();
      @(negedge clk);
      n_done = 0;
      n_err  = 0;
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      idle(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CLK_DIV);
      end
      rx = stop_bit;
      idle(CLK_DIV);
      rx = 1'b1;
      idle(3);
   endtask

   // Sends A5 then frame_q; appends the XOR checksum (or 0x00 when bad) in checksum builds.
   task automatic send_frame(input logic bad_chk);
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'hA5, 1'b1);
      foreach (frame_q[i]) begin
         send_byte(frame_q[i], 1'b1);
         x = x ^ frame_q[i];
      end
`ifdef SONG_WR_CHECKSUM_EN
      send_byte(bad_chk ? 8'h00 : x, 1'b1);
`else
      if (bad_chk) x = 8'h00;
`endif
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check({tag, "_wr"}, {4'h0, wr_q[i]}, {4'h0, exp_q[i]});
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b1;
      rx = 1'b1;
      idle(4);
      check("rst_addr", addr_c, 0);
      check("rst_data", data_c, 0);
      check("rst_wen", wen_c, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_last_len", last_len, 0);
      rst = 1'b0;
      idle(10);

      // nominal two-note frame
      clear_obs();
      frame_q = '{8'h02, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF};
      exp_q = '{{16'h0200, 12'h123}, {16'h0201, 12'hFFF}};
      send_frame(1'b0);
      idle(20);
      check_writes("nominal");
      check("nominal_done", n_done, 1);
      check("nominal_err", n_err, 0);
      check("nominal_last_len", last_len, 2);
      check("nominal_busy", busy, 0);
`ifndef SONG_WR_CHECKSUM_EN
      check("nominal_done_with_wen", done_cyc, wen_cyc);
`endif

`ifdef SONG_WR_CHECKSUM_EN
      // bad checksum: writes stand, err instead of done
      clear_obs();
      exp_q = '{{16'h0200, 12'h123}, {16'h0201, 12'hFFF}};
      send_frame(1'b1);
      idle(20);
      check_writes("badchk");
      check("badchk_done", n_done, 0);
      check("badchk_err", n_err, 1);
      check("badchk_last_len", last_len, 2);
`endif

      // SEL out of range
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h09, 1'b1);
      idle(10);
      check_writes("sel9");
      check("sel9_err", n_err, 1);
      check("sel9_busy", busy, 0);

      // LEN zero
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(10);
      check_writes("len0");
      check("len0_err", n_err, 1);

      // noise byte in IDLE
      clear_obs();
      send_byte(8'h55, 1'b1);
      idle(10);
      check("noise_err", n_err, 0);
      check("noise_done", n_done, 0);
      check("noise_busy", busy, 0);

      // framing error mid-frame
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h3C, 1'b0);
      idle(CLK_DIV);
      check("frame_err", n_err, 1);
      check("frame_busy", busy, 0);

      // short glitch between bytes of a one-note frame must not misalign it
      clear_obs();
      exp_q = '{{16'h0200, 12'h123}};
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h01, 1'b1);
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(2 * CLK_DIV);
      check("glitch_err", n_err, 0);
      check("glitch_busy", busy, 1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h23, 1'b1);
`ifdef SONG_WR_CHECKSUM_EN
      send_byte(8'h21, 1'b1);
`endif
      idle(20);
      check_writes("glitch");
      check("glitch_done", n_done, 1);
      check("glitch_last_len", last_len, 1);

      // inter-byte timeout
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      idle(500);
      check("timeout_err", n_err, 1);
      check("timeout_busy", busy, 0);
      check("timeout_done", n_done, 0);

      // enable dropped after first HI byte
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h05, 1'b1);
      enable = 1'b0;
      idle(5);
      check("endrop_err", n_err, 1);
      check("endrop_busy", busy, 0);
      check_writes("endrop");

      // whole frame with enable low
      clear_obs();
      frame_q = '{8'h04, 8'h01, 8'h07, 8'h89};
      send_frame(1'b0);
      idle(20);
      check_writes("disabled");
      check("disabled_done", n_done, 0);
      check("disabled_err", n_err, 0);
      enable = 1'b1;
      idle(5);

      // reset right after the SEL byte
      clear_obs();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h05, 1'b1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_last_len", last_len, 0);
      check("midrst_addr", addr_c, 0);
      check("midrst_data", data_c, 0);
      check("midrst_pulses", {wen_c, done, err}, 0);
      idle(10);
      check("midrst_err", n_err, 0);
      check("midrst_done", n_done, 0);
      clear_obs();
      frame_q = '{8'h05, 8'h01, 8'h0A, 8'hBC};
      exp_q = '{{16'h0500, 12'hABC}};
      send_frame(1'b0);
      idle(20);
      check_writes("post_rst");
      check("post_rst_done", n_done, 1);
      check("post_rst_err", n_err, 0);
      check("post_rst_last_len", last_len, 1);

      check("done_err_overlap", n_both, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/song_writer.md
# song_writer

UART-fed song loader that writes note words into the music-box song register file while the design is in writing mode. It contains an 8N1 serial receiver and a frame parser. Each received note pair becomes one 12-bit regfile write on the `addr_c`/`data_c`/`wen_c` write port, which is the write-side counterpart of the song reader. It sits between the `UART_RX` pin and `regfile`, gated by `writing` from `model_ctl`.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200).
- `TIMEOUT`, 1000000: max idle cycles between bytes inside a frame.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `enable` input 1: write mode permit (`writing` from `model_ctl`).
- `rx` input 1: UART line, idle high, asynchronous to `clk`.
- `addr_c` output 16: regfile write address `{5'b0, sel[2:0], idx[7:0]}`.
- `data_c` output 12: note word.
- `wen_c` output 1: one-cycle write strobe.
- `busy` output 1: high while a frame is in progress (parser not IDLE).
- `done` output 1: one-cycle pulse on successful frame end.
- `err` output 1: one-cycle pulse on any abort.
- `last_len` output 8: note count of the last successful frame.

## Operation
- Frame format: `0xA5`, SEL, LEN, then LEN × (HI, LO), then CHK (CHK only with the macro).
- Note word: `{HI[3:0], LO[7:0]}`. `HI[7:4]` is ignored.
- Receiver:
  - 2-flop synchroniser, both flops reset to 1.
  - A falling edge in RX_IDLE starts a byte.
  - The start bit is re-sampled at CLK_DIV/2. If it reads high, treat it as a glitch and return to idle with no error.
  - 8 data bits, LSB first, are sampled every CLK_DIV cycles thereafter.
  - The stop bit is sampled. If it is 1, assert internal `rx_valid` for 1 cycle. If it is 0, signal a framing error and discard the byte.
- Parser states: IDLE, SEL, LEN, NOTE_HI, NOTE_LO, CHK.
  - IDLE: byte `0xA5` → SEL. Any other byte is ignored with no error.
  - SEL: byte >7 → err, IDLE. Otherwise latch `sel` → LEN.
  - LEN: 0 → err, IDLE. Otherwise latch `len`, set `idx`=0 → NOTE_HI.
  - NOTE_HI: latch HI → NOTE_LO.
  - NOTE_LO: issue a write, then `idx`+1.
    - If `idx` was `len`-1, go to CHK (macro on), or to IDLE with `done` (macro off).
    - Otherwise go to NOTE_HI.
  - CHK: byte equals the running XOR of SEL, LEN and all note bytes → `done`. Otherwise `err`. Both go to IDLE.
- On `done`, latch `last_len` = `len`.
- Aborts: each pulses `err` once, returns to IDLE, and does not roll back writes already made.
  - A framing error while busy.
  - Inter-byte gap > TIMEOUT while busy.
  - `enable` falling while busy.
- A framing error in IDLE is silent.
- `enable` low: `rx_valid` bytes are dropped and the parser stays in IDLE. The receiver keeps running so that byte alignment is preserved.
- Address arithmetic: `idx` is 8 bits and never wraps, because LEN ≤ 255.

## Timing
- Reset values:
  - All outputs are 0.
  - Parser is in IDLE; receiver is in RX_IDLE.
  - Checksum and timeout counters are 0.
- Reset asserted mid-frame: the next cycle is clean idle. No `err` or `done` pulse is produced.
- Write latency: `wen_c` is high exactly the cycle after the LO byte's `rx_valid`. `addr_c`/`data_c` are valid in that same cycle and hold until the next write.
- `done`/`err` latency: asserted the cycle after the deciding `rx_valid`, or the cycle after the timeout/`enable` event.
- `done` and `err` are never high in the same cycle.
- Priority when events coincide: `rst` > `enable` drop > timeout > byte.
- Timeout counter: clears on every `rx_valid` and in IDLE. Abort fires when the count reaches TIMEOUT.
- Byte time is 10×CLK_DIV cycles. `rx_valid` fires at mid-stop-bit, about 9.5×CLK_DIV cycles after the falling edge.

## Configuration
- `SONG_WR_CHECKSUM_EN` defined:
  - The CHK byte is required.
  - `done` requires a checksum match; a mismatch pulses `err`.
- `SONG_WR_CHECKSUM_EN` undefined:
  - No CHK state and no XOR register.
  - `done` pulses with the last note write: it is asserted the cycle after the final LO byte, in the same cycle as `wen_c`.

## Test plan
All cases use CLK_DIV=16 and TIMEOUT=400.
- Nominal frame, macro on: `enable`=1, send A5 02 02 01 23 0F FF, CHK=0x02^0x02^0x01^0x23^0x0F^0xFF=0xD2.
  - Writes (0x0200, 0x123) and (0x0201, 0xFFF).
  - `done` pulses once; `last_len`=2; `err` never asserted.
- Bad checksum: same frame with CHK=0x00.
  - The two writes still occur.
  - `err` pulses once; `done` stays 0; `last_len` unchanged.
- Header errors:
  - A5 09 → `err`, no write.
  - A5 01 00 → `err`, no write.
  - Noise byte 0x55 in IDLE → nothing happens.
- Framing and glitch:
  - Byte with stop bit 0 mid-frame → `err`, parser in IDLE.
  - 4-cycle low glitch on `rx` → no `rx_valid`, no `err`.
- Timeout and `enable`:
  - Stall 500 cycles after the LEN byte → `err` once.
  - Drop `enable` after the first HI byte → `err` once, `busy`=0.
  - `enable`=0 for a full frame → no writes.
- Reset mid-frame: assert `rst` for 1 cycle after the SEL byte.
  - All outputs are 0 the next cycle; no pulses.
  - A subsequent full frame completes normally.
